// File: rtl/nv_nvdla_cdp_mcif_rd_responder_if.sv
// Client-facing request/response, credit and SRAM signals of the CDP read responder.
// The responder takes the slave view; the client/bench side takes the master view.
interface nv_nvdla_cdp_mcif_rd_responder_if #(
  parameter int ADDR_W = 10
);
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [78:0]       rd_req_pd;
  logic              rd_rsp_valid;
  logic              rd_rsp_ready;
  logic [256:0]      rd_rsp_pd;
  logic              rd_cdt_lat_fifo_pop;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_rd_addr;
  logic [255:0]      sram_rd_data;
  logic              cdt_err;
  logic              idle;

  modport slave (
    input  rd_req_valid, rd_req_pd, rd_rsp_ready, rd_cdt_lat_fifo_pop, sram_rd_data,
    output rd_req_ready, rd_rsp_valid, rd_rsp_pd, sram_rd_en, sram_rd_addr, cdt_err, idle
  );

  modport master (
    output rd_req_valid, rd_req_pd, rd_rsp_ready, rd_cdt_lat_fifo_pop, sram_rd_data,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_pd, sram_rd_en, sram_rd_addr, cdt_err, idle
  );
endinterface

// File: rtl/nv_nvdla_cdp_mcif_rd_responder.sv
// CDP read responder: queues read requests, expands them into 32-byte atom reads
// of a local SRAM and returns one response beat per atom under latency-FIFO credits.
module nv_nvdla_cdp_mcif_rd_responder #(
  parameter int ADDR_W    = 10,
  parameter int REQ_DEPTH = 4,
  parameter int LAT_DEPTH = 8
) (
  input  logic                                   nvdla_core_clk,
  input  logic                                   nvdla_core_rst,
  nv_nvdla_cdp_mcif_rd_responder_if.slave        bus
);

  localparam int QW = $clog2(REQ_DEPTH);
  localparam int CW = $clog2(LAT_DEPTH + 1);
  localparam logic [CW-1:0]     CDT_MAX  = CW'(LAT_DEPTH);
  localparam logic [CW-1:0]     CDT_ONE  = CW'(1);
  localparam logic [QW:0]       PTR_ONE  = (QW + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [14:0]       SIZE_ONE = 15'd1;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  // Request FIFO
  logic [ADDR_W-1:0] r_q_addr [REQ_DEPTH];
  logic [14:0]       r_q_size [REQ_DEPTH];
  logic [QW:0]       r_q_wp, r_q_rp;
  logic              w_q_full, w_q_empty, w_q_push, w_q_pop;
  logic [ADDR_W-1:0] w_head_addr;
  logic [14:0]       w_head_size;
  logic              w_unused_pd_bits;

  // Issue engine, credits and output buffer
  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr, w_addr_nxt, w_issue_addr;
  logic [14:0]       r_rem, w_rem_nxt;
  logic [CW-1:0]     r_credit;
  logic              r_cdt_err;
  logic              r_inflight;
  logic [255:0]      r_ob_data [2];
  logic              r_ob_wp, r_ob_rp;
  logic [1:0]        r_ob_cnt;
  logic              w_issue, w_can_issue, w_room, w_rsp_valid, w_rsp_pop;

  assign w_q_empty   = (r_q_wp == r_q_rp);
  assign w_q_full    = (r_q_wp[QW] != r_q_rp[QW]) && (r_q_wp[QW-1:0] == r_q_rp[QW-1:0]);
  assign w_q_push    = bus.rd_req_valid && bus.rd_req_ready;
  assign w_head_addr = r_q_addr[r_q_rp[QW-1:0]];
  assign w_head_size = r_q_size[r_q_rp[QW-1:0]];
  assign w_unused_pd_bits = ^{bus.rd_req_pd[63:ADDR_W+5], bus.rd_req_pd[4:0]};

  assign bus.rd_req_ready = !nvdla_core_rst && !w_q_full;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_q_wp <= '0;
      r_q_rp <= '0;
    end else begin
      if (w_q_push) r_q_wp <= r_q_wp + PTR_ONE;
      if (w_q_pop)  r_q_rp <= r_q_rp + PTR_ONE;
    end
  end

  // NOTE: storage arrays carry no reset; the pointers alone decide which entries are live.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_q_push) begin
      r_q_addr[r_q_wp[QW-1:0]] <= bus.rd_req_pd[ADDR_W+4:5];
      r_q_size[r_q_wp[QW-1:0]] <= bus.rd_req_pd[78:64];
    end
  end

  assign w_rsp_valid = !nvdla_core_rst && (r_ob_cnt != 2'd0);
  assign w_rsp_pop   = w_rsp_valid && bus.rd_rsp_ready;
  // A beat leaving this cycle frees its slot, which keeps the pipe at one beat per cycle.
  assign w_room      = (r_ob_cnt - {1'b0, w_rsp_pop} + {1'b0, r_inflight}) < 2'd2;
  assign w_can_issue = !nvdla_core_rst && (r_credit != '0) && w_room;

  // NOTE: combinational blocks use blocking assignments with every output defaulted first, so no latches.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_cur_addr;
    w_rem_nxt    = r_rem;
    w_issue      = 1'b0;
    w_issue_addr = '0;
    w_q_pop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_q_empty && !nvdla_core_rst) begin
          w_q_pop     = 1'b1;
          w_state_nxt = S_RUN;
          w_addr_nxt  = w_head_addr;
          w_rem_nxt   = w_head_size;
          if (w_can_issue) begin
            w_issue      = 1'b1;
            w_issue_addr = w_head_addr;
            w_addr_nxt   = w_head_addr + ADDR_ONE;
            if (w_head_size == 15'd0) w_state_nxt = S_IDLE;
            else                      w_rem_nxt   = w_head_size - SIZE_ONE;
          end
        end
      end
      S_RUN: begin
        if (w_can_issue) begin
          w_issue      = 1'b1;
          w_issue_addr = r_cur_addr;
          w_addr_nxt   = r_cur_addr + ADDR_ONE;
          if (r_rem == 15'd0) w_state_nxt = S_IDLE;
          else                w_rem_nxt   = r_rem - SIZE_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state    <= S_IDLE;
      r_cur_addr <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
      r_ob_wp    <= 1'b0;
      r_ob_rp    <= 1'b0;
      r_ob_cnt   <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_addr <= w_addr_nxt;
      r_rem      <= w_rem_nxt;
      r_inflight <= w_issue;
      if (r_inflight) r_ob_wp <= ~r_ob_wp;
      if (w_rsp_pop)  r_ob_rp <= ~r_ob_rp;
      r_ob_cnt   <= r_ob_cnt + {1'b0, r_inflight} - {1'b0, w_rsp_pop};
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (r_inflight) r_ob_data[r_ob_wp] <= bus.sram_rd_data;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_credit  <= CDT_MAX;
      r_cdt_err <= 1'b0;
    end else begin
      unique case ({w_issue, bus.rd_cdt_lat_fifo_pop})
        2'b10: r_credit <= r_credit - CDT_ONE;
        2'b01: begin
          if (r_credit == CDT_MAX) r_cdt_err <= 1'b1;
          else                     r_credit  <= r_credit + CDT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_rsp_valid = w_rsp_valid;
  assign bus.rd_rsp_pd    = w_rsp_valid ? {1'b1, r_ob_data[r_ob_rp]} : '0;
  assign bus.sram_rd_en   = w_issue;
  assign bus.sram_rd_addr = w_issue_addr;
  assign bus.cdt_err      = r_cdt_err;
  assign bus.idle         = nvdla_core_rst ||
                            (w_q_empty && (r_state == S_IDLE) && !r_inflight && (r_ob_cnt == 2'd0));

endmodule
